// File: rtl/dmem_arbiter_if.sv
//------------------------------------------------------------------------------
// dmem_arbiter_if
//
// One requester port of the data-memory arbiter: request/grant handshake,
// access fields and the one-cycle-latency read response.
//
//   req     requester -> arbiter  request, held until gnt
//   we      requester -> arbiter  1 = write, 0 = read
//   addr    requester -> arbiter  word address
//   wdata   requester -> arbiter  write data
//   be      requester -> arbiter  byte enables (writes only)
//   gnt     arbiter -> requester  request accepted this cycle (combinational)
//   rvalid  arbiter -> requester  read data valid (cycle after a read grant)
//   rdata   arbiter -> requester  read data, 0 when rvalid is low
//
// Modports: master = requester side (core LSU, debug/loader),
//           slave  = arbiter side.
//------------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the core load/store unit and a
// debug/loader master. At most one access is issued per cycle; the winner's
// fields drive the memory combinationally and the one-cycle-latency read data
// is routed back to whichever requester issued the read.
//
// Arbitration (state ARB): a lone requester is granted; on a tie the requester
// not granted most recently wins (last_grant resets to dbg, so core wins the
// first tie). The debug master can take exclusive ownership (state LOCKED) by
// being granted with dbg_lock=1; ownership ends on the first cycle sampled
// with dbg_lock=0.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high reset
//   core       slave modport of dmem_arbiter_if (core LSU)
//   dbg        slave modport of dmem_arbiter_if (debug/loader master)
//   dbg_lock   in   debug master requests exclusive ownership
//   mem_en     out  memory access strobe
//   mem_we     out  memory write
//   mem_addr   out  memory word address
//   mem_wdata  out  memory write data
//   mem_be     out  memory byte enables
//   mem_rdata  in   memory read data, valid the cycle after a read access
//   locked     out  arbiter is in state LOCKED
//
// Build option:
//   DMEM_ARB_STARVE_GUARD_EN  when defined, a 4-bit counter counts LOCKED
//   cycles in which core is requesting; at 15 the core is granted once and the
//   arbiter returns to ARB. When undefined, LOCKED lasts until dbg_lock drops.
//------------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  dmem_arbiter_if.slave       core,
  dmem_arbiter_if.slave       dbg,
  input  logic                dbg_lock,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                locked
);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  typedef enum logic {
    SRC_CORE = 1'b0,
    SRC_DBG  = 1'b1
  } src_t;

  state_t state, state_next;
  src_t   last_grant;
  src_t   rd_owner;
  logic   rd_pending;
  logic   grant_core;
  logic   grant_dbg;
  logic   force_core;
  logic   rd_issue;

  //----------------------------------------------------------------------------
  // Starvation guard: forces one core grant out of a long LOCKED period.
  //----------------------------------------------------------------------------
`ifdef DMEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign force_core = (state == ST_LOCKED) && core.req && (starve_cnt == 4'hF);

  always_ff @(posedge clk) begin
    // Cleared whenever the arbiter is not going to be LOCKED next cycle, which
    // covers reset, the normal unlock and the forced exit.
    if (reset || (state_next != ST_LOCKED)) begin
      starve_cnt <= '0;
    end else if ((state == ST_LOCKED) && core.req) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_core = 1'b0;
`endif

  //----------------------------------------------------------------------------
  // Grant decision and next state. Reset suppresses every grant so a request
  // in the reset cycle never reaches the memory.
  //----------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the if/case leaves it unassigned and infers a latch.
    grant_core = 1'b0;
    grant_dbg  = 1'b0;
    state_next = state;

    if (!reset) begin
      case (state)
        ST_ARB: begin
          if (core.req && (!dbg.req || (last_grant == SRC_DBG))) begin
            grant_core = 1'b1;
          end else if (dbg.req) begin
            grant_dbg = 1'b1;
          end
          if (grant_dbg && dbg_lock) begin
            state_next = ST_LOCKED;
          end
        end

        ST_LOCKED: begin
          // Core is blocked; the only exception is the starvation-guard cycle,
          // where core takes priority over the lock owner.
          if (force_core) begin
            grant_core = 1'b1;
          end else begin
            grant_dbg = dbg.req;
          end
          if (!dbg_lock || force_core) begin
            state_next = ST_ARB;
          end
        end

        default: state_next = ST_ARB;
      endcase
    end
  end

  assign core.gnt = grant_core;
  assign dbg.gnt  = grant_dbg;

  //----------------------------------------------------------------------------
  // Memory-side mux: the winner's fields pass straight through, unmodified.
  //----------------------------------------------------------------------------
  always_comb begin
    mem_en    = grant_core | grant_dbg;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (grant_core) begin
      mem_we    = core.we;
      mem_addr  = core.addr;
      mem_wdata = core.wdata;
      mem_be    = core.be;
    end else if (grant_dbg) begin
      mem_we    = dbg.we;
      mem_addr  = dbg.addr;
      mem_wdata = dbg.wdata;
      mem_be    = dbg.be;
    end
  end

  assign rd_issue = mem_en && !mem_we;

  //----------------------------------------------------------------------------
  // State, fairness history and read-response tracking.
  //----------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state      <= ST_ARB;
      last_grant <= SRC_DBG;
      rd_pending <= 1'b0;
      rd_owner   <= SRC_CORE;
    end else begin
      state <= state_next;
      // Fairness history only moves on ARB grants; LOCKED leaves it alone.
      if ((state == ST_ARB) && (grant_core || grant_dbg)) begin
        last_grant <= grant_core ? SRC_CORE : SRC_DBG;
      end
      // A new read may be accepted in the same cycle the previous one returns.
      rd_pending <= rd_issue;
      if (rd_issue) begin
        rd_owner <= grant_core ? SRC_CORE : SRC_DBG;
      end
    end
  end

  //----------------------------------------------------------------------------
  // Response routing. Gating with reset drops a response that is in flight
  // when reset arrives, so no outputs leave their reset values that cycle.
  //----------------------------------------------------------------------------
  assign core.rvalid = !reset && rd_pending && (rd_owner == SRC_CORE);
  assign dbg.rvalid  = !reset && rd_pending && (rd_owner == SRC_DBG);
  assign core.rdata  = core.rvalid ? mem_rdata : '0;
  assign dbg.rdata   = dbg.rvalid  ? mem_rdata : '0;

  assign locked = !reset && (state == ST_LOCKED);

endmodule

// File: tb/tb_dmem_arbiter.sv
//------------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. A 1024-word byte-enabled memory with
// one-cycle read latency sits on the memory side. Inputs change 1 time unit
// after a rising edge; outputs are sampled 1 time unit after that, well away
// from the next rising edge.
//------------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              dbg_lock;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              locked;

  logic [DATA_W-1:0] mem [0:1023];

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) core_if ();
  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbg_if ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .core      (core_if),
    .dbg       (dbg_if),
    .dbg_lock  (dbg_lock),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port data memory: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    core_if.req = 1'b0; core_if.we = 1'b0; core_if.addr = '0; core_if.wdata = '0; core_if.be = '0;
    dbg_if.req  = 1'b0; dbg_if.we  = 1'b0; dbg_if.addr  = '0; dbg_if.wdata  = '0; dbg_if.be  = '0;
    dbg_lock    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[65]   = 32'd7;
    mem[66]   = 32'd2;
    mem_rdata = '0;

    //--------------------------------------------------------------------------
    // Reset: requests asserted together with reset are not granted.
    //--------------------------------------------------------------------------
    idle_inputs();
    reset = 1'b1;
    core_if.req = 1'b1;
    dbg_if.req  = 1'b1;
    tick();
    settle();
    check("rst_core_gnt", core_if.gnt, 1'b0);
    check("rst_dbg_gnt", dbg_if.gnt, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_core_rvalid", core_if.rvalid, 1'b0);
    check("rst_dbg_rvalid", dbg_if.rvalid, 1'b0);
    check("rst_core_rdata", core_if.rdata, 32'd0);
    check("rst_dbg_rdata", dbg_if.rdata, 32'd0);
    check("rst_locked", locked, 1'b0);
    idle_inputs();
    reset = 1'b0;
    tick();

    //--------------------------------------------------------------------------
    // Core-only read of addr 65 (holds 7).
    //--------------------------------------------------------------------------
    core_if.req = 1'b1; core_if.we = 1'b0; core_if.addr = 10'd65;
    settle();
    check("rd_core_gnt", core_if.gnt, 1'b1);
    check("rd_dbg_gnt", dbg_if.gnt, 1'b0);
    check("rd_mem_en", mem_en, 1'b1);
    check("rd_mem_we", mem_we, 1'b0);
    check("rd_mem_addr", mem_addr, 10'd65);
    tick();
    core_if.req = 1'b0;
    settle();
    check("rd_core_rvalid", core_if.rvalid, 1'b1);
    check("rd_core_rdata", core_if.rdata, 32'd7);
    check("rd_dbg_rvalid", dbg_if.rvalid, 1'b0);
    check("rd_dbg_rdata", dbg_if.rdata, 32'd0);
    check("rd_idle_mem_en", mem_en, 1'b0);
    tick();

    //--------------------------------------------------------------------------
    // Simultaneous: core read 66, dbg write 0xA5 to addr 10. Core wins first.
    //--------------------------------------------------------------------------
    do_reset();
    core_if.req = 1'b1; core_if.we = 1'b0; core_if.addr = 10'd66;
    dbg_if.req = 1'b1; dbg_if.we = 1'b1; dbg_if.addr = 10'd10; dbg_if.wdata = 32'hA5; dbg_if.be = 4'hF;
    settle();
    check("sim_core_gnt", core_if.gnt, 1'b1);
    check("sim_dbg_gnt0", dbg_if.gnt, 1'b0);
    tick();
    core_if.req = 1'b0;
    settle();
    check("sim_core_rvalid", core_if.rvalid, 1'b1);
    check("sim_core_rdata", core_if.rdata, 32'd2);
    check("sim_dbg_gnt1", dbg_if.gnt, 1'b1);
    check("sim_mem_we", mem_we, 1'b1);
    check("sim_mem_addr", mem_addr, 10'd10);
    check("sim_mem_wdata", mem_wdata, 32'hA5);
    tick();
    dbg_if.req = 1'b0;
    settle();
    check("sim_dbg_rvalid_wr", dbg_if.rvalid, 1'b0);
    check("sim_core_rvalid_end", core_if.rvalid, 1'b0);
    check("sim_mem10", mem[10], 32'hA5);

    //--------------------------------------------------------------------------
    // Continuous contention (last winner dbg): core, dbg, core, dbg, core, dbg.
    // Each cycle also returns the previous winner's read data.
    //--------------------------------------------------------------------------
    core_if.req = 1'b1; core_if.we = 1'b0; core_if.addr = 10'd65;
    dbg_if.req  = 1'b1; dbg_if.we  = 1'b0; dbg_if.addr  = 10'd66;
    for (int i = 0; i < 6; i++) begin
      settle();
      check($sformatf("alt_core_gnt_%0d", i), core_if.gnt, (i % 2) == 0);
      check($sformatf("alt_dbg_gnt_%0d", i), dbg_if.gnt, (i % 2) == 1);
      if (i > 0) begin
        check($sformatf("alt_core_rdata_%0d", i), core_if.rdata, ((i % 2) == 1) ? 32'd7 : 32'd0);
        check($sformatf("alt_dbg_rdata_%0d", i), dbg_if.rdata, ((i % 2) == 0) ? 32'd2 : 32'd0);
      end
      tick();
    end
    idle_inputs();
    tick();

    //--------------------------------------------------------------------------
    // Lock burst: dbg writes addrs 0..3 with dbg_lock=1, core keeps requesting.
    //--------------------------------------------------------------------------
    do_reset();
    core_if.req = 1'b1; core_if.we = 1'b0; core_if.addr = 10'd66;
    dbg_if.req = 1'b1; dbg_if.we = 1'b1; dbg_if.addr = 10'd0; dbg_if.wdata = 32'h100; dbg_if.be = 4'hF;
    dbg_lock = 1'b1;
    settle();
    check("lk_c0_core_gnt", core_if.gnt, 1'b1);
    check("lk_c0_locked", locked, 1'b0);
    tick();
    settle();
    check("lk_c1_dbg_gnt", dbg_if.gnt, 1'b1);
    check("lk_c1_core_gnt", core_if.gnt, 1'b0);
    check("lk_c1_locked", locked, 1'b0);
    check("lk_c1_core_rdata", core_if.rdata, 32'd2);
    tick();
    for (int k = 1; k < 4; k++) begin
      dbg_if.addr = 10'(k);
      dbg_if.wdata = 32'h100 + 32'(k);
      settle();
      check($sformatf("lk_locked_%0d", k), locked, 1'b1);
      check($sformatf("lk_dbg_gnt_%0d", k), dbg_if.gnt, 1'b1);
      check($sformatf("lk_core_gnt_%0d", k), core_if.gnt, 1'b0);
      check($sformatf("lk_mem_addr_%0d", k), mem_addr, 10'(k));
      tick();
    end
    // Locked but dbg idle: memory idle, core still blocked.
    dbg_if.req = 1'b0;
    settle();
    check("lk_idle_locked", locked, 1'b1);
    check("lk_idle_core_gnt", core_if.gnt, 1'b0);
    check("lk_idle_mem_en", mem_en, 1'b0);
    tick();
    // Lock released in cycle N: still LOCKED in N, ARB and core granted in N+1.
    dbg_lock = 1'b0;
    settle();
    check("lk_n_locked", locked, 1'b1);
    check("lk_n_core_gnt", core_if.gnt, 1'b0);
    tick();
    settle();
    check("lk_n1_locked", locked, 1'b0);
    check("lk_n1_core_gnt", core_if.gnt, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("lk_mem_%0d", k), mem[k], 32'h100 + 32'(k));
    end
    idle_inputs();
    tick();

    // dbg_lock without dbg_req does not lock.
    dbg_lock = 1'b1;
    tick();
    settle();
    check("lock_noreq_locked", locked, 1'b0);
    dbg_lock = 1'b0;
    tick();

    //--------------------------------------------------------------------------
    // Reset mid-read: pending response is dropped; arbitration restarts.
    //--------------------------------------------------------------------------
    core_if.req = 1'b1; core_if.we = 1'b0; core_if.addr = 10'd65;
    settle();
    check("mr_core_gnt", core_if.gnt, 1'b1);
    tick();
    core_if.req = 1'b0;
    reset = 1'b1;
    settle();
    check("mr_core_rvalid", core_if.rvalid, 1'b0);
    check("mr_core_rdata", core_if.rdata, 32'd0);
    check("mr_mem_en", mem_en, 1'b0);
    tick();
    settle();
    check("mr_core_rvalid_after", core_if.rvalid, 1'b0);
    check("mr_locked", locked, 1'b0);
    reset = 1'b0;
    // Tie after reset goes to core (last_grant back to dbg).
    core_if.req = 1'b1; core_if.addr = 10'd66;
    dbg_if.req = 1'b1; dbg_if.we = 1'b0; dbg_if.addr = 10'd65;
    settle();
    check("mr_tie_core_gnt", core_if.gnt, 1'b1);
    check("mr_tie_dbg_gnt", dbg_if.gnt, 1'b0);
    tick();
    idle_inputs();
    tick();

    //--------------------------------------------------------------------------
    // Top address and partial byte enables pass through unmodified.
    //--------------------------------------------------------------------------
    dbg_if.req = 1'b1; dbg_if.we = 1'b1; dbg_if.addr = 10'h3FF;
    dbg_if.wdata = 32'hDEADBEEF; dbg_if.be = 4'b0011;
    settle();
    check("top_mem_addr", mem_addr, 10'h3FF);
    check("top_mem_be", mem_be, 4'b0011);
    check("top_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    idle_inputs();
    settle();
    check("top_mem1023", mem[1023], 32'h0000BEEF);
    tick();

`ifdef DMEM_ARB_STARVE_GUARD_EN
    //--------------------------------------------------------------------------
    // Starvation guard: core blocked 15 cycles, then granted once; unlocked.
    //--------------------------------------------------------------------------
    do_reset();
    dbg_if.req = 1'b1; dbg_if.we = 1'b0; dbg_if.addr = 10'd5;
    dbg_lock = 1'b1;
    settle();
    check("sg_dbg_gnt", dbg_if.gnt, 1'b1);
    tick();
    core_if.req = 1'b1; core_if.we = 1'b0; core_if.addr = 10'd65;
    for (int c = 0; c < 15; c++) begin
      settle();
      check($sformatf("sg_blocked_%0d", c), core_if.gnt, 1'b0);
      tick();
    end
    settle();
    check("sg_force_core_gnt", core_if.gnt, 1'b1);
    check("sg_force_dbg_gnt", dbg_if.gnt, 1'b0);
    tick();
    core_if.req = 1'b0;
    settle();
    check("sg_unlocked", locked, 1'b0);
    idle_inputs();
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the core load/store unit and a debug/loader master (testbench loader or debug module). It sits between `core_top`'s data-side port and the `data_memory` instance. It issues at most one memory access per cycle and routes the one-cycle-latency read data back to the winning requester. A lock state lets the debug master own memory for back-to-back bursts.

## Interface
Parameters:
- `ADDR_W`, 10: word address width (1024 words).
- `DATA_W`, 32: data width; byte enables are `DATA_W/8` bits wide.

Ports:
- `clk`  in  1  single clock; everything samples on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `core_req`  in  1  core request; held until granted.
- `core_we`  in  1  1 = write, 0 = read.
- `core_addr`  in  ADDR_W  word address.
- `core_wdata`  in  DATA_W  write data.
- `core_be`  in  DATA_W/8  byte enables (writes only).
- `core_gnt`  out  1  request accepted this cycle (combinational).
- `core_rvalid`  out  1  read data valid (registered).
- `core_rdata`  out  DATA_W  read data.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_be`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same as the `core_*` set, for the debug master.
- `dbg_lock`  in  1  debug requests exclusive ownership.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_be`  out  DATA_W/8  memory byte enables.
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after a read access.
- `locked`  out  1  state is LOCKED.

## Operation
- State machine:
  - ARB (reset state): normal arbitration.
  - LOCKED: debug master owns the memory.
  - ARB -> LOCKED when `dbg_gnt & dbg_lock`.
  - LOCKED -> ARB on the first cycle sampled with `dbg_lock=0`.
- Arbitration in ARB:
  - Only one requester active: it is granted.
  - Both active: the requester not granted most recently wins, tracked by a `last_grant` register (reset value = dbg, so core wins the first tie).
- In LOCKED:
  - Only `dbg_req` can be granted.
  - `core_gnt=0` regardless of `core_req`.
  - `last_grant` is not updated.
- When a grant is given, the winner's `we/addr/wdata/be` drive `mem_*` combinationally and `mem_en=1`. Otherwise `mem_en=0` and `mem_we=0`.
- Reads:
  - A one-bit owner register and a pending flag capture the granted read.
  - Next cycle, the owner's `rvalid=1` and `rdata=mem_rdata`. The other requester's `rvalid=0` and its `rdata` holds 0.
- Writes produce no `rvalid`.
- Accepting a new request in the same cycle a previous read's `rvalid` is driven is allowed (full throughput).
- A requester may drop `req` only after it has been granted. Changing fields while waiting is illegal (unchecked).

## Timing
- Grant latency: 0 cycles (same cycle as `req` when the requester wins).
- Read data latency: 1 cycle after the grant.
- Throughput: one access per cycle in total.
- With both requesters continuously requesting in ARB, grants strictly alternate. Worst-case wait is 1 cycle.
- Reset values: `mem_en=0`, `mem_we=0`, all gnt/rvalid = 0, all rdata = 0, `locked=0`, state ARB, pending flag cleared.
- Reset mid-read: a pending `rvalid` is dropped and no response is delivered.
- Reset and requests asserted in the same cycle: reset wins and no grant is given.
- `dbg_lock` raised without `dbg_req`: no state change.
- In LOCKED with `dbg_req=0`: memory is idle and core stays blocked.
- Address wrap: none. Addresses pass through unmodified.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN`:
  - Defined: a 4-bit counter increments each LOCKED cycle in which `core_req=1`. On reaching 15 it forces LOCKED -> ARB and grants core once (core has priority on that cycle). The counter clears on leaving LOCKED.
  - Undefined: LOCKED persists until `dbg_lock` drops, and core can starve indefinitely.

## Test plan
- Core-only read: core read from addr 65 with mem[65]=7 -> `core_gnt` in cycle N, `core_rvalid=1` and `core_rdata=7` in N+1, `dbg_rvalid=0`.
- Simultaneous requests: core read addr 66 (=2) and dbg write addr 10 data 0xA5 both held -> core granted first, dbg next cycle; mem[10]=0xA5; `core_rdata=2`.
- Continuous contention, 6 cycles: grant sequence core, dbg, core, dbg, core, dbg.
- Lock burst: dbg writes addrs 0..3 with `dbg_lock=1` while `core_req=1`:
  - `locked=1` from the cycle after the first dbg grant; core never granted while `dbg_lock=1`.
  - `dbg_lock` is deasserted in cycle N, so `locked` drops at edge N+1 and core is granted in N+1.
- Reset mid-read: core read granted, then `reset=1` the next cycle -> `core_rvalid=0`, all outputs at reset values, state ARB.
- With `DMEM_ARB_STARVE_GUARD_EN`: dbg holds the lock with continuous requests and core requests -> core granted once after 15 blocked cycles, then `locked=0`.
